// File: rtl/msync_gen.sv
// msync_gen: master sync pulse generator driving msync_n to the znd_blk,
// data_blk and eth_top channel consumers.
//
// Ports:
//   clk20      20 MHz clock
//   res_n      asynchronous active-low reset
//   mode       0 off, 1 internal timer, 2 wheel encoder, 3 external sync
//   period     internal timer period in clk20 cycles (values below 2 act as 2)
//   wheel_div  forward x4 encoder steps per sync (0 acts as 1)
//   holdoff    idle cycles enforced after each pulse
//   clr_ovr    level clear for overrun and quad_err
//   adp, bdp   wheel encoder phases A/B (asynchronous)
//   sync       external sync, active high (asynchronous)
//   msync_n    registered active-low sync pulse, PULSE_W cycles wide
//   sync_cnt   pulses issued, wrapping
//   wheel_pos  signed x4 encoder position, wrapping
//   wheel_dir  direction of last valid step (1 = forward)
//   overrun    sticky: a trigger arrived while busy and was dropped
//   quad_err   sticky: both encoder phases changed in the same cycle
module msync_gen #(
    parameter int PULSE_W = 4,
    parameter int FILT    = 3,
    parameter int PER_W   = 24
) (
    input  logic             clk20,
    input  logic             res_n,
    input  logic [1:0]       mode,
    input  logic [PER_W-1:0] period,
    input  logic [7:0]       wheel_div,
    input  logic [15:0]      holdoff,
    input  logic             clr_ovr,
    input  logic             adp,
    input  logic             bdp,
    input  logic             sync,
    output logic             msync_n,
    output logic [15:0]      sync_cnt,
    output logic [31:0]      wheel_pos,
    output logic             wheel_dir,
    output logic             overrun,
    output logic             quad_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [2:0] raw, flt, chg;
    logic [1:0] ini;

    assign raw = {sync, bdp, adp};

    // Per input: two-flop synchronizer, then a stability filter. Until the
    // init flag is set the filter just tracks the input silently, so the
    // first stable level after reset never produces a step or an edge.
    for (genvar i = 0; i < 3; i++) begin : g_flt
        logic       s1_q, s2_q, f_q, f_d, ini_q, ini_d;
        logic [3:0] c_q, c_d;
        always_comb begin
            f_d   = f_q;
            ini_d = ini_q;
            c_d   = '0;
            if (!ini_q) begin
                f_d   = s2_q;
                ini_d = (s1_q == s2_q) && (s2_q == f_q) && (c_q == 4'(FILT - 1));
                c_d   = ((s1_q == s2_q) && (s2_q == f_q) && !ini_d) ? c_q + 4'd1 : '0;
            end else if (s2_q != f_q) begin
                f_d = (c_q == 4'(FILT - 1)) ? s2_q : f_q;
                c_d = (c_q == 4'(FILT - 1)) ? '0 : c_q + 4'd1;
            end
        end
        always_ff @(posedge clk20 or negedge res_n) begin
            if (!res_n) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                f_q   <= 1'b0;
                ini_q <= 1'b0;
                c_q   <= '0;
            end else begin
                s1_q  <= raw[i];
                s2_q  <= s1_q;
                f_q   <= f_d;
                ini_q <= ini_d;
                c_q   <= c_d;
            end
        end
        assign flt[i] = f_q;
        assign chg[i] = ini_q && (f_d != f_q);
        if (i < 2) begin : g_ini
            assign ini[i] = ini_q;
        end
    end

    // Quadrature decode on the pre-change {A,B}: a B change from an equal
    // pair, or an A change from an unequal pair, is a forward step.
    logic q_step, q_fwd, q_err;
    assign q_err  = &ini && chg[0] && chg[1];
    assign q_step = &ini && (chg[0] ^ chg[1]);
    assign q_fwd  = chg[1] ? (flt[0] == flt[1]) : (flt[0] != flt[1]);

    logic [1:0]        mode_q;
    logic              mode_chg;
    logic [PER_W-1:0]  tmr_q, tmr_d, per_eff;
    logic signed [8:0] acc_q, acc_d, acc_inc, div;
    logic              tmr_hit, whl_hit, req;
    logic [31:0]       pos_q, pos_d;
    logic              dir_q, dir_d;

    assign mode_chg = mode != mode_q;
    assign per_eff  = (period < PER_W'(2)) ? PER_W'(2) : period;
    assign tmr_hit  = tmr_q == per_eff - PER_W'(1);
    assign div      = (wheel_div == 8'd0) ? 9'sd1 : $signed({1'b0, wheel_div});
    assign acc_inc  = acc_q + 9'sd1;
    // >= rather than == so a wheel_div lowered below the running count fires
    // on the next forward step instead of overflowing the accumulator.
    assign whl_hit  = q_step && q_fwd && (acc_inc >= div);
    assign req      = !mode_chg && (((mode == 2'd1) && tmr_hit)
                                 || ((mode == 2'd2) && whl_hit)
                                 || ((mode == 2'd3) && chg[2] && !flt[2]));

    always_comb begin
        tmr_d = (mode_chg || (mode != 2'd1) || tmr_hit) ? '0 : tmr_q + PER_W'(1);
        acc_d = (mode_chg || (mode != 2'd2)) ? 9'sd0 :
                !q_step                      ? acc_q :
                q_fwd                        ? (whl_hit ? 9'sd0 : acc_inc) :
                (acc_q == -9'sd255)          ? acc_q : acc_q - 9'sd1;
        pos_d = !q_step ? pos_q : q_fwd ? pos_q + 32'd1 : pos_q - 32'd1;
        dir_d = q_step ? q_fwd : dir_q;
    end

    logic [1:0]  st_q, st_d;
    logic [7:0]  pcnt_q, pcnt_d;
    logic [15:0] hcnt_q, hcnt_d, hold_q, hold_d, scnt_q, scnt_d;
    logic        msync_q, ovr_q, ovr_d, qerr_q, qerr_d;

    always_comb begin
        st_d   = st_q;
        pcnt_d = pcnt_q;
        hcnt_d = hcnt_q;
        hold_d = hold_q;
        scnt_d = scnt_q;
        case (st_q)
            IDLE: if (req) begin
                st_d   = LOW;
                pcnt_d = '0;
                scnt_d = scnt_q + 16'd1;
            end
            LOW: if (pcnt_q == 8'(PULSE_W - 1)) begin
                st_d   = (holdoff == 16'd0) ? IDLE : HOLD;
                hcnt_d = '0;
                hold_d = holdoff;
            end else begin
                pcnt_d = pcnt_q + 8'd1;
            end
            HOLD: if (hcnt_q == hold_q - 16'd1) st_d = IDLE;
                  else hcnt_d = hcnt_q + 16'd1;
            default: st_d = IDLE;
        endcase
        // Set has priority over a simultaneous clear.
        ovr_d  = (req && (st_q != IDLE)) ? 1'b1 : clr_ovr ? 1'b0 : ovr_q;
        qerr_d = q_err ? 1'b1 : clr_ovr ? 1'b0 : qerr_q;
    end

    always_ff @(posedge clk20 or negedge res_n) begin
        if (!res_n) begin
            mode_q  <= 2'd0;
            tmr_q   <= '0;
            acc_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            st_q    <= IDLE;
            pcnt_q  <= '0;
            hcnt_q  <= '0;
            hold_q  <= '0;
            scnt_q  <= '0;
            msync_q <= 1'b1;
            ovr_q   <= 1'b0;
            qerr_q  <= 1'b0;
        end else begin
            mode_q  <= mode;
            tmr_q   <= tmr_d;
            acc_q   <= acc_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            st_q    <= st_d;
            pcnt_q  <= pcnt_d;
            hcnt_q  <= hcnt_d;
            hold_q  <= hold_d;
            scnt_q  <= scnt_d;
            msync_q <= st_d != LOW;
            ovr_q   <= ovr_d;
            qerr_q  <= qerr_d;
        end
    end

    assign msync_n   = msync_q;
    assign sync_cnt  = scnt_q;
    assign wheel_pos = pos_q;
    assign wheel_dir = dir_q;
    assign overrun   = ovr_q;
    assign quad_err  = qerr_q;
endmodule

// File: tb/tb_msync_gen.sv
// tb_msync_gen: self-checking bench for msync_gen; expected pulse start
// cycles are queued as stimulus is applied and matched as pulses appear.
module tb_msync_gen;
    logic        clk20 = 1'b0, res_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] period = 24'd1000;
    logic [7:0]  wheel_div = 8'd8;
    logic [15:0] holdoff = 16'd0;
    logic        clr_ovr = 1'b0, adp = 1'b0, bdp = 1'b0, sync = 1'b0;
    logic        msync_n, wheel_dir, overrun, quad_err;
    logic [15:0] sync_cnt;
    logic [31:0] wheel_pos;

    int   cyc = 0, errors = 0, checks = 0, lw = 0, e = 0, k = 0;
    int   exp_q[$];
    logic prev_n = 1'b1;

    typedef struct {
        logic [1:0] ab;
        int         pos;
        logic       dir;
        logic       fire;
    } vec_t;
    vec_t       tbl[32];
    logic [1:0] gray[4];

    msync_gen dut (
        .clk20(clk20), .res_n(res_n), .mode(mode), .period(period),
        .wheel_div(wheel_div), .holdoff(holdoff), .clr_ovr(clr_ovr),
        .adp(adp), .bdp(bdp), .sync(sync), .msync_n(msync_n),
        .sync_cnt(sync_cnt), .wheel_pos(wheel_pos), .wheel_dir(wheel_dir),
        .overrun(overrun), .quad_err(quad_err)
    );

    initial forever #5 clk20 = ~clk20;
    initial forever begin
        @(posedge clk20);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step_to(input int t);
        while (cyc < t) begin
            @(posedge clk20);
            #1;
        end
    endtask

    // Pulse monitor: each falling msync_n must match the oldest queued start
    // cycle, and each pulse not cut short by reset must be 4 cycles wide.
    initial forever begin
        @(negedge clk20);
        if (prev_n && !msync_n) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_start: unexpected pulse at cycle %0d, expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL pulse_start: got cycle %0d expected cycle %0d", cyc, e);
                end
            end
            lw = 1;
        end else if (!msync_n) begin
            lw++;
        end else if (!prev_n && res_n) begin
            checks++;
            if (lw != 4) begin
                errors++;
                $display("FAIL pulse_width: got %0d expected 4", lw);
            end
        end
        prev_n = msync_n;
    end

    initial begin
        gray = '{2'b00, 2'b01, 2'b11, 2'b10};
        begin
            int p;
            p = 0;
            for (int i = 0; i < 32; i++) begin
                p += (i < 16 || i >= 24) ? 1 : -1;
                tbl[i].pos  = p;
                tbl[i].dir  = (i < 16 || i >= 24);
                tbl[i].fire = (i == 7 || i == 15);
                tbl[i].ab   = gray[p & 3];
            end
        end

        repeat (3) @(posedge clk20);
        #1;
        chk("rst_msync_n", 32'(msync_n), 1);
        chk("rst_sync_cnt", 32'(sync_cnt), 0);
        chk("rst_wheel_pos", wheel_pos, 0);
        chk("rst_wheel_dir", 32'(wheel_dir), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_quad_err", 32'(quad_err), 0);
        res_n = 1'b1;
        step_to(cyc + 10);

        // Internal timer, then a switch to mode 0 in the middle of the 5th pulse.
        k = cyc;
        mode = 2'd1;
        for (int j = 1; j <= 5; j++) exp_q.push_back(k + 1 + 1000 * j);
        step_to(k + 5002);
        mode = 2'd0;
        step_to(k + 5010);
        chk("timer_sync_cnt", 32'(sync_cnt), 5);
        chk("timer_overrun", 32'(overrun), 0);
        step_to(k + 6600);
        k = cyc;
        mode = 2'd1;
        exp_q.push_back(k + 1001);
        step_to(k + 1005);
        mode = 2'd0;
        step_to(k + 2200);
        chk("restart_sync_cnt", 32'(sync_cnt), 6);

        // Wheel: 16 forward, 8 reverse, 8 forward with wheel_div = 8.
        k = cyc;
        mode = 2'd2;
        step_to(k + 5);
        for (int i = 0; i < 32; i++) begin
            k = cyc;
            {adp, bdp} = tbl[i].ab;
            if (tbl[i].fire) exp_q.push_back(k + 5);
            step_to(k + 12);
            chk("wheel_pos", wheel_pos, 32'(tbl[i].pos));
            chk("wheel_dir", 32'(wheel_dir), 32'(tbl[i].dir));
        end
        chk("wheel_sync_cnt", 32'(sync_cnt), 8);

        // External sync with holdoff, plus single-cycle glitches.
        mode = 2'd3;
        holdoff = 16'd100;
        step_to(cyc + 5);
        sync = 1'b1;
        step_to(cyc + 1);
        sync = 1'b0;
        step_to(cyc + 15);
        adp = 1'b1;
        step_to(cyc + 1);
        adp = 1'b0;
        step_to(cyc + 15);
        chk("glitch_wheel_pos", wheel_pos, 16);
        chk("glitch_wheel_dir", 32'(wheel_dir), 1);
        k = cyc;
        sync = 1'b1;
        exp_q.push_back(k + 5);
        step_to(k + 10);
        sync = 1'b0;
        step_to(k + 50);
        sync = 1'b1;
        step_to(k + 60);
        sync = 1'b0;
        step_to(k + 70);
        chk("drop_overrun", 32'(overrun), 1);
        chk("drop_sync_cnt", 32'(sync_cnt), 9);
        step_to(k + 150);
        clr_ovr = 1'b1;
        step_to(cyc + 1);
        clr_ovr = 1'b0;
        step_to(cyc + 2);
        chk("clr_overrun", 32'(overrun), 0);
        k = cyc;
        sync = 1'b1;
        exp_q.push_back(k + 5);
        step_to(k + 10);
        sync = 1'b0;
        step_to(k + 200);
        sync = 1'b1;
        exp_q.push_back(k + 205);
        step_to(k + 210);
        sync = 1'b0;
        step_to(k + 330);
        chk("spaced_overrun", 32'(overrun), 0);
        chk("spaced_sync_cnt", 32'(sync_cnt), 11);

        // Both encoder phases flip together.
        k = cyc;
        adp = 1'b1;
        bdp = 1'b1;
        step_to(k + 12);
        chk("abflip_quad_err", 32'(quad_err), 1);
        chk("abflip_wheel_pos", wheel_pos, 16);
        clr_ovr = 1'b1;
        step_to(cyc + 1);
        clr_ovr = 1'b0;
        step_to(cyc + 2);
        chk("clr_quad_err", 32'(quad_err), 0);

        // Asynchronous reset while msync_n is low.
        k = cyc;
        sync = 1'b1;
        exp_q.push_back(k + 5);
        step_to(k + 6);
        chk("pre_reset_msync_n", 32'(msync_n), 0);
        #2 res_n = 1'b0;
        #1 chk("async_reset_msync_n", 32'(msync_n), 1);
        step_to(cyc + 3);
        res_n = 1'b1;
        step_to(cyc + 20);
        chk("post_reset_msync_n", 32'(msync_n), 1);
        chk("post_reset_sync_cnt", 32'(sync_cnt), 0);
        chk("post_reset_wheel_pos", wheel_pos, 0);
        chk("post_reset_wheel_dir", 32'(wheel_dir), 0);
        chk("post_reset_overrun", 32'(overrun), 0);
        chk("post_reset_quad_err", 32'(quad_err), 0);

        chk("pending_pulses", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
